// File: rtl/serial_slave_mem.sv
// serial_slave_mem: bit-serial bus slave with an internal word memory and a pausable read return path.
// Define SLAVE_BURST_EN to add a burst length field, address auto-increment and gapless multi-word streaming.
module serial_slave_mem #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 4096,
    parameter int BURST_BITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic validIn,
    input  logic wren,
    input  logic Address,
    input  logic DataIn,
    input  logic BusAvailable,
    output logic ready,
    output logic validOut,
    output logic DataOut,
    output logic slaveErr
);
    localparam int MAX_AD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAX_W  = (MAX_AD > BURST_BITS) ? MAX_AD : BURST_BITS;
    localparam int CW     = $clog2(MAX_W + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_WDATA, S_WRITE, S_RFETCH, S_RDATA
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    wren_q, wren_d;
`ifdef SLAVE_BURST_EN
    logic [BURST_BITS-1:0]   len_q, len_d;
    logic                    wcommit_q, wcommit_d;
    logic [ADDR_WIDTH-1:0]   addr_inc;
`endif

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    in_range;
    logic                    mem_we;
    logic                    err;

    assign in_range  = {1'b0, addr_q} < DEPTH_L;
    assign mem_rdata = mem[addr_q];
`ifdef SLAVE_BURST_EN
    assign addr_inc  = (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        shift_d = shift_q;
        wren_d  = wren_q;
        mem_we  = 1'b0;
        err     = 1'b0;
`ifdef SLAVE_BURST_EN
        len_d     = len_q;
        wcommit_d = 1'b0;
        // A finished non-final burst word commits while the next word's first bit arrives.
        if (wcommit_q) begin
            mem_we = in_range;
            err    = !in_range;
            addr_d = addr_inc;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (validIn) begin
                    wren_d  = wren;
                    addr_d  = {Address, addr_q[ADDR_WIDTH-1:1]};
                    cnt_d   = CW'(1);
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                addr_d = {Address, addr_q[ADDR_WIDTH-1:1]};
                if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                    cnt_d   = '0;
`ifdef SLAVE_BURST_EN
                    state_d = S_LEN;
`else
                    state_d = wren_q ? S_WDATA : S_RFETCH;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SLAVE_BURST_EN
            S_LEN: begin
                len_d             = len_q >> 1;
                len_d[BURST_BITS-1] = Address;
                if (cnt_q == CW'(BURST_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = wren_q ? S_WDATA : S_RFETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_WDATA: begin
                wdata_d = {DataIn, wdata_q[DATA_WIDTH-1:1]};
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    cnt_d = '0;
`ifdef SLAVE_BURST_EN
                    if (len_q == '0) begin
                        state_d = S_WRITE;
                    end else begin
                        wcommit_d = 1'b1;
                        len_d     = len_q - 1'b1;
                    end
`else
                    state_d = S_WRITE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                mem_we  = in_range;
                err     = !in_range;
                state_d = S_IDLE;
            end
            S_RFETCH: begin
                shift_d = in_range ? mem_rdata : '0;
                err     = !in_range;
                cnt_d   = '0;
                state_d = S_RDATA;
`ifdef SLAVE_BURST_EN
                addr_d  = addr_inc;
`endif
            end
            S_RDATA: begin
                if (BusAvailable) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        cnt_d = '0;
`ifdef SLAVE_BURST_EN
                        // Next word is read straight into the shifter so the stream has no gap.
                        if (len_q == '0) begin
                            state_d = S_IDLE;
                        end else begin
                            len_d   = len_q - 1'b1;
                            shift_d = in_range ? mem_rdata : '0;
                            err     = !in_range;
                            addr_d  = addr_inc;
                        end
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            wren_q    <= 1'b0;
`ifdef SLAVE_BURST_EN
            len_q     <= '0;
            wcommit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            wren_q    <= wren_d;
`ifdef SLAVE_BURST_EN
            len_q     <= len_d;
            wcommit_q <= wcommit_d;
`endif
        end
    end

    // Memory has no reset; a reset edge blocks any commit in flight.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign validOut = (state_q == S_RDATA) && BusAvailable;
    assign DataOut  = (state_q == S_RDATA) && shift_q[0];
    assign slaveErr = err;

endmodule

// File: tb/tb_serial_slave_mem.sv
// Directed + randomised bench for serial_slave_mem (MEM_DEPTH=3000); burst steps build with SLAVE_BURST_EN.
module tb_serial_slave_mem;
    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 3000;
    localparam int BB    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic validIn = 1'b0;
    logic wren = 1'b0;
    logic Address = 1'b0;
    logic DataIn = 1'b0;
    logic BusAvailable = 1'b0;
    logic ready, validOut, DataOut, slaveErr;

    always #5 clk = ~clk;

    serial_slave_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BURST_BITS(BB)
    ) dut (
        .clk(clk), .rst(rst), .validIn(validIn), .wren(wren), .Address(Address),
        .DataIn(DataIn), .BusAvailable(BusAvailable), .ready(ready),
        .validOut(validOut), .DataOut(DataOut), .slaveErr(slaveErr)
    );

    int total = 0;
    int bad = 0;
    logic [0:0]    exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] wbuf [16];
`ifdef SLAVE_BURST_EN
    logic [BB-1:0] burst_len = '0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
        return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    // All driving and sampling happens just after the falling edge.
    task automatic send_start(input logic w, input logic [AW-1:0] a);
        check("ready_idle", ready, 1'b1);
        validIn = 1'b1;
        wren    = w;
        Address = a[0];
        @(negedge clk);
        validIn = 1'b0;
        wren    = 1'b0;
    endtask

    task automatic send_hdr(input logic [AW-1:0] a);
        for (int i = 1; i < AW; i++) begin
            Address = a[i];
            @(negedge clk);
            check("ready_busy", ready, 1'b0);
        end
`ifdef SLAVE_BURST_EN
        for (int i = 0; i < BB; i++) begin
            Address = burst_len[i];
            @(negedge clk);
        end
`endif
        Address = 1'b0;
    endtask

    task automatic write_body(input logic [AW-1:0] a, input int nwords, input logic exp_err,
                              input logic chain, input logic [AW-1:0] chain_a);
        logic [AW-1:0] wa;
        wa = a;
        for (int w = 0; w < nwords; w++) begin
            for (int i = 0; i < DW; i++) begin
                DataIn = wbuf[w][i];
                @(negedge clk);
            end
            if (!exp_err) model_mem[wa] = wbuf[w];
            wa = nxt(wa);
        end
        DataIn = 1'b0;
        check("write_ready_low", ready, 1'b0);
        check("write_err", slaveErr, exp_err);
        if (chain) begin
            validIn = 1'b1;
            wren    = 1'b0;
            Address = chain_a[0];
        end
        @(negedge clk);
        check("write_ready_high", ready, 1'b1);
        check("write_err_clear", slaveErr, 1'b0);
        if (chain) begin
            @(negedge clk);
            validIn = 1'b0;
            Address = 1'b0;
        end
    endtask

    task automatic read_body(input logic [AW-1:0] a, input int nwords, input logic exp_err,
                             input int first_hold, input int stall_at, input int stall_len);
        logic [AW-1:0] ra;
        logic [DW-1:0] word;
        int hold;
        check("rfetch_err", slaveErr, exp_err);
        check("rfetch_valid", validOut, 1'b0);
        ra = a;
        for (int w = 0; w < nwords; w++) begin
            word = exp_err ? '0 : model_mem[ra];
            for (int i = 0; i < DW; i++) exp_q.push_back(word[i]);
            ra = nxt(ra);
        end
        @(negedge clk);
        for (int b = 0; b < nwords * DW; b++) begin
            hold = 0;
            if (b == 0) hold = first_hold;
            else if (b == stall_at) hold = stall_len;
            for (int s = 0; s < hold; s++) begin
                BusAvailable = 1'b0;
                #1;
                check("stall_valid", validOut, 1'b0);
                check("stall_data", DataOut, exp_q[0]);
                check("stall_ready", ready, 1'b0);
                @(negedge clk);
            end
            BusAvailable = 1'b1;
            #1;
            check("rd_valid", validOut, 1'b1);
            check("rd_bit", DataOut, exp_q.pop_front());
            @(negedge clk);
        end
        BusAvailable = 1'b0;
        #1;
        check("rd_end_ready", ready, 1'b1);
        check("rd_end_valid", validOut, 1'b0);
        check("rd_end_data", DataOut, 1'b0);
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic exp_err);
        wbuf[0] = d;
        send_start(1'b1, a);
        send_hdr(a);
        write_body(a, 1, exp_err, 1'b0, '0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic exp_err,
                           input int first_hold, input int stall_at, input int stall_len);
        send_start(1'b0, a);
        send_hdr(a);
        read_body(a, 1, exp_err, first_hold, stall_at, stall_len);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic [AW-1:0] abort_a;

        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_valid", validOut, 1'b0);
        check("rst_data", DataOut, 1'b0);
        check("rst_err", slaveErr, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", ready, 1'b1);

        // Basic write then ungated read of 0xA5.
        do_write(12'h024, 8'hA5, 1'b0);
        do_read(12'h024, 1'b0, 0, -1, 0);

        // Return path paused: idle grant at start, then a 4-cycle pause after 3 bits.
        do_read(12'h024, 1'b0, 3, 3, 4);

        // Out-of-range write and read leave in-range contents alone.
        do_write(12'h000, 8'h77, 1'b0);
        do_write(12'hFFF, 8'h3C, 1'b1);
        do_read(12'hFFF, 1'b1, 0, -1, 0);
        do_read(12'h000, 1'b0, 0, -1, 0);

        // Reset on the 5th address bit of a write aborts it.
        abort_a = 12'h024;
        send_start(1'b1, abort_a);
        for (int i = 1; i < 4; i++) begin
            Address = abort_a[i];
            @(negedge clk);
        end
        Address = abort_a[4];
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", ready, 1'b1);
        check("abort_valid", validOut, 1'b0);
        check("abort_err", slaveErr, 1'b0);
        Address = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        do_read(12'h024, 1'b0, 0, -1, 0);
        do_write(12'h100, 8'h5A, 1'b0);
        do_read(12'h100, 1'b0, 0, -1, 0);

        // validIn alongside rst: reset wins.
        rst = 1'b1;
        validIn = 1'b1;
        wren = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        validIn = 1'b0;
        wren = 1'b0;
        check("rst_wins_ready", ready, 1'b1);
        @(negedge clk);
        check("rst_wins_idle", ready, 1'b1);

        // Back-to-back: validIn held across WRITE->IDLE starts the read at once.
        wbuf[0] = 8'hC3;
        send_start(1'b1, 12'h200);
        send_hdr(12'h200);
        write_body(12'h200, 1, 1'b0, 1'b1, 12'h200);
        check("chain_started", ready, 1'b0);
        send_hdr(12'h200);
        read_body(12'h200, 1, 1'b0, 0, -1, 0);

        for (int k = 0; k < 6; k++) begin
            ra = AW'($urandom_range(0, DEPTH - 1));
            rd = DW'($urandom_range(0, 255));
            do_write(ra, rd, 1'b0);
            do_read(ra, 1'b0, $urandom_range(0, 2), $urandom_range(1, DW - 1), $urandom_range(1, 3));
        end

`ifdef SLAVE_BURST_EN
        // Burst wrapping from DEPTH-1 to 0.
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        wbuf[2] = 8'h33;
        burst_len = BB'(2);
        send_start(1'b1, AW'(DEPTH - 1));
        send_hdr(AW'(DEPTH - 1));
        write_body(AW'(DEPTH - 1), 3, 1'b0, 1'b0, '0);
        send_start(1'b0, AW'(DEPTH - 1));
        send_hdr(AW'(DEPTH - 1));
        read_body(AW'(DEPTH - 1), 3, 1'b0, 0, -1, 0);
        burst_len = '0;
        do_read(12'h000, 1'b0, 0, -1, 0);
        do_read(12'h001, 1'b0, 0, -1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
